// File: rtl/shift_cmd_pkg.sv
// Shared types for the shift-unit command driver: op encodings, FSM states, data width
// and the reference shift function used by the optional result checker.
package shift_cmd_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_CMPL = 2'b01,
    OP_SHR  = 2'b10,
    OP_SHL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    SETTLE = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Vectors here are MSB-first numerically, so a right shift moves bits toward the
  // port-side index 3 and a left shift toward index 0, both zero filled.
  function automatic logic [DATA_W-1:0] shift_ref(input logic [DATA_W-1:0] data,
                                                  input op_e op,
                                                  input logic [1:0] amt);
    logic [DATA_W-1:0] res;
    res = data;
    unique case (op)
      OP_PASS: res = data;
      OP_CMPL: res = ~data;
      OP_SHR:  res = data >> amt;
      OP_SHL:  res = data << amt;
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_cmd_ref_model.sv
// Combinational expected result of the shift unit for a given operand, op and amount.
// Pure function wrapper, no state.
module shift_cmd_ref_model
  import shift_cmd_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_op,
  input  logic [1:0]        i_amt,
  output logic [DATA_W-1:0] o_res
);

  assign o_res = shift_ref(i_data, op_e'(i_op), i_amt);

endmodule

// File: rtl/shift_cmd_driver.sv
// Drives the 4-bit universal shift unit from a valid/ready command channel and returns the
// captured result on a valid/ready response channel. Optional checker: SHIFT_CMD_DRIVER_CHECK_EN.
module shift_cmd_driver
  import shift_cmd_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [0:3]       req_data,
  input  logic [0:1]       req_op,
  input  logic [0:1]       req_amt,
  input  logic             req_chain,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [0:3]       rsp_data,
  output logic             sd_load,
  output logic             sd_rg,
  output logic [0:1]       sd_ch,
  output logic [0:1]       sd_sh,
  output logic [0:3]       sd_in,
  input  logic [0:3]       sd_out,
  output logic [CNT_W-1:0] done_cnt
`ifdef SHIFT_CMD_DRIVER_CHECK_EN
  ,
  output logic             chk_err,
  output logic [CNT_W-1:0] chk_cnt
`endif
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  op_e               r_op;
  logic [1:0]        r_amt;
  logic              r_chain;
  logic [2:0]        r_settle;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_done_cnt;

  logic              w_accept;
  logic              w_settle_last;
  logic              w_rsp_fire;
  logic [1:0]        w_amt_eff;

  assign w_accept      = req_valid && (r_state == IDLE);
  assign w_settle_last = (r_state == SETTLE) && (r_settle == SETTLE_LAST);
  assign w_rsp_fire    = r_rsp_valid && rsp_ready;
  // Pass and complement ignore the amount; keep the unit's amount select quiet for them.
  assign w_amt_eff     = ((r_op == OP_SHR) || (r_op == OP_SHL)) ? r_amt : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid)     w_state_nxt = LOAD;
      LOAD:                       w_state_nxt = SETTLE;
      SETTLE:  if (w_settle_last) w_state_nxt = RESP;
      RESP:    if (w_rsp_fire)    w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Control lines fall back to 00 outside LOAD/SETTLE so sd_out shows the stored result.
  always_comb begin
    req_ready = 1'b0;
    sd_load   = 1'b0;
    sd_rg     = 1'b0;
    sd_in     = '0;
    sd_ch     = '0;
    sd_sh     = '0;
    unique case (r_state)
      IDLE: req_ready = 1'b1;
      LOAD: begin
        sd_load = 1'b1;
        sd_rg   = r_chain;
        sd_in   = r_data;
        sd_ch   = r_op;
        sd_sh   = w_amt_eff;
      end
      SETTLE: begin
        sd_ch = r_op;
        sd_sh = w_amt_eff;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data      <= '0;
      r_op        <= OP_PASS;
      r_amt       <= '0;
      r_chain     <= 1'b0;
      r_settle    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_done_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= req_data;
        r_op    <= op_e'(req_op);
        r_amt   <= req_amt;
        r_chain <= req_chain;
      end
      if (r_state == LOAD) begin
        r_settle <= '0;
      end else if ((r_state == SETTLE) && !w_settle_last) begin
        r_settle <= r_settle + 3'd1;
      end
      if (w_settle_last) begin
        r_rsp_data  <= sd_out;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_done_cnt  <= r_done_cnt + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign done_cnt  = r_done_cnt;

`ifdef SHIFT_CMD_DRIVER_CHECK_EN
  logic [DATA_W-1:0] w_chk_src;
  logic [DATA_W-1:0] w_chk_exp;
  logic              r_chk_err;
  logic [CNT_W-1:0]  r_chk_cnt;

  // A chained command operates on the previous result, which rsp_data still holds here.
  assign w_chk_src = r_chain ? r_rsp_data : r_data;

  shift_cmd_ref_model u_ref (
    .i_data (w_chk_src),
    .i_op   (r_op),
    .i_amt  (w_amt_eff),
    .o_res  (w_chk_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk_err <= 1'b0;
      r_chk_cnt <= '0;
    end else if (w_settle_last && (sd_out != w_chk_exp)) begin
      r_chk_err <= 1'b1;
      if (r_chk_cnt != '1) begin
        r_chk_cnt <= r_chk_cnt + 1'b1;
      end
    end
  end

  assign chk_err = r_chk_err;
  assign chk_cnt = r_chk_cnt;
`endif

endmodule

// File: tb/tb_shift_cmd_driver.sv
// Bench for shift_cmd_driver with a behavioural shift unit on the sd_* ports and a
// result scoreboard; the checker outputs are exercised when SHIFT_CMD_DRIVER_CHECK_EN is set.
module tb_shift_cmd_driver;
  import shift_cmd_pkg::*;

  localparam int SETTLE_CYC = 1;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [0:3]       req_data = '0;
  logic [0:1]       req_op = '0;
  logic [0:1]       req_amt = '0;
  logic             req_chain = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [0:3]       rsp_data;
  logic             sd_load;
  logic             sd_rg;
  logic [0:1]       sd_ch;
  logic [0:1]       sd_sh;
  logic [0:3]       sd_in;
  logic [0:3]       sd_out;
  logic [CNT_W-1:0] done_cnt;
`ifdef SHIFT_CMD_DRIVER_CHECK_EN
  logic             chk_err;
  logic [CNT_W-1:0] chk_cnt;
`endif

  always #5 clk = ~clk;

  shift_cmd_driver #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_op    (req_op),
    .req_amt   (req_amt),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .sd_load   (sd_load),
    .sd_rg     (sd_rg),
    .sd_ch     (sd_ch),
    .sd_sh     (sd_sh),
    .sd_in     (sd_in),
    .sd_out    (sd_out),
    .done_cnt  (done_cnt)
`ifdef SHIFT_CMD_DRIVER_CHECK_EN
    ,
    .chk_err   (chk_err),
    .chk_cnt   (chk_cnt)
`endif
  );

  // Shift unit: the register stores the shifted value of its source on load; rg recirculates it.
  logic [3:0] r_unit;
  logic [3:0] w_unit_src;
  logic [3:0] w_unit_res;
  logic [3:0] r_corrupt = 4'b0000;

  assign w_unit_src = sd_rg ? r_unit : 4'(sd_in);
  assign sd_out     = r_unit ^ r_corrupt;

  shift_cmd_ref_model u_unit (
    .i_data (w_unit_src),
    .i_op   (sd_ch),
    .i_amt  (sd_sh),
    .o_res  (w_unit_res)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) r_unit <= 4'b0000;
    else if (sd_load) r_unit <= w_unit_res;
  end

  int         n_chk = 0;
  int         n_err = 0;
  logic [3:0] sb_q[$];
  logic [3:0] m_last = 4'b0000;
  int         m_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] bench_shift(input logic [3:0] d, input logic [1:0] op,
                                             input logic [1:0] amt);
    logic [3:0] r;
    case (op)
      2'b00: r = d;
      2'b01: r = {~d[3], ~d[2], ~d[1], ~d[0]};
      2'b10: case (amt)
               2'd0: r = d;
               2'd1: r = {1'b0, d[3:1]};
               2'd2: r = {2'b00, d[3:2]};
               default: r = {3'b000, d[3]};
             endcase
      default: case (amt)
               2'd0: r = d;
               2'd1: r = {d[2:0], 1'b0};
               2'd2: r = {d[1:0], 2'b00};
               default: r = {d[0], 3'b000};
             endcase
    endcase
    return r;
  endfunction

  task automatic do_cmd(input logic [3:0] d, input logic [1:0] op, input logic [1:0] amt,
                        input logic ch, input int hold, input logic [3:0] exp);
    int n;
    int lat;
    logic [3:0] held;
    logic [3:0] want;
    @(posedge clk); #1;
    req_data = d; req_op = op; req_amt = amt; req_chain = ch; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("accept", req_ready, 1);
    sb_q.push_back(exp ^ r_corrupt);
    m_last = exp ^ r_corrupt;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("load_pulse", sd_load, 1);
    check_eq("load_sd_in", sd_in, d);
    check_eq("load_sd_rg", sd_rg, ch);
    check_eq("load_sd_ch", sd_ch, op);
    check_eq("load_sd_sh", sd_sh, op[1] ? amt : 2'b00);
    check_eq("busy_ready", req_ready, 0);
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        check_eq("load_one_cycle", sd_load, 0);
        check_eq("settle_sd_ch", sd_ch, op);
      end
    end while (!rsp_valid && lat < 40);
    check_eq("latency", lat, 2 + SETTLE_CYC);
    check_eq("resp_ctl_idle", {sd_ch, sd_sh}, 0);
    held = rsp_data;
    if (hold > 0) req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", rsp_valid, 1);
      check_eq("bp_data", rsp_data, held);
      check_eq("bp_ready", req_ready, 0);
      check_eq("bp_no_load", sd_load, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check_eq("sb_size", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      want = sb_q.pop_front();
      check_eq("rsp_data", rsp_data, want);
    end
    m_cnt++;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_drop", rsp_valid, 0);
    check_eq("ready_after", req_ready, 1);
    check_eq("done_cnt", done_cnt, m_cnt % (1 << CNT_W));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [3:0] d;
    logic [1:0] op;
    logic [1:0] amt;
    logic       ch;

    repeat (2) @(negedge clk);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_sd", {sd_load, sd_rg, sd_ch, sd_sh, sd_in}, 0);
    check_eq("rst_done_cnt", done_cnt, 0);
    reset = 1'b1;

    do_cmd(4'b1011, 2'b01, 2'b11, 1'b0, 0, 4'b0100);
    do_cmd(4'b1011, 2'b10, 2'b10, 1'b0, 0, 4'b0010);
    do_cmd(4'b1001, 2'b00, 2'b10, 1'b0, 0, 4'b1001);
    do_cmd(4'b1011, 2'b11, 2'b01, 1'b0, 0, 4'b0110);
    do_cmd(4'b1111, 2'b10, 2'b01, 1'b1, 0, 4'b0011);
    do_cmd(4'b0101, 2'b11, 2'b10, 1'b0, 5, 4'b0100);

    // Abandon a command mid-SETTLE.
    @(posedge clk); #1;
    req_data = 4'b1100; req_op = 2'b00; req_amt = 2'b00; req_chain = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", rsp_valid, 0);
    check_eq("mid_rst_ready", req_ready, 1);
    check_eq("mid_rst_load", sd_load, 0);
    check_eq("mid_rst_cnt", done_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("no_stale_rsp", seen, 0);
    m_cnt = 0;
    m_last = 4'b0000;

    do_cmd(4'b1111, 2'b10, 2'b01, 1'b1, 0, 4'b0000);

    for (int i = 0; i < 255; i++) begin
      d   = 4'($urandom);
      op  = 2'($urandom);
      amt = 2'($urandom);
      ch  = 1'($urandom_range(0, 3) == 0);
      do_cmd(d, op, amt, ch, (i % 64 == 5) ? 2 : 0, bench_shift(ch ? m_last : d, op, amt));
    end
    check_eq("wrap_done_cnt", done_cnt, 0);

`ifdef SHIFT_CMD_DRIVER_CHECK_EN
    check_eq("chk_err_clean", chk_err, 0);
    check_eq("chk_cnt_clean", chk_cnt, 0);
    r_corrupt = 4'b0110;
    do_cmd(4'b0011, 2'b00, 2'b00, 1'b0, 0, 4'b0011);
    r_corrupt = 4'b0000;
    check_eq("chk_err_set", chk_err, 1);
    check_eq("chk_cnt_one", chk_cnt, 1);
    do_cmd(4'b1000, 2'b10, 2'b11, 1'b0, 0, 4'b0001);
    check_eq("chk_err_sticky", chk_err, 1);
    check_eq("chk_cnt_hold", chk_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_cmd_driver.md
Name: shift_cmd_driver

Overview:
- Initiator-side controller for the 4-bit universal shift unit.
- Accepts one shift command per valid/ready transaction and drives the unit's control lines (load, rg, ch, sh, in).
- Captures the unit's combinational result and returns it on a valid/ready response channel.
- Sits between the system command bus and the shift unit. The shift unit is a separate instance wired to the sd_* ports.

Parameters:
- SETTLE_CYC, 1: cycles between the register load edge and the result capture (1..7).
- CNT_W, 8: width of the completed-command counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  command valid
- req_ready  output  1  driver can accept a command
- req_data  input  [0:3]  operand, bit 0 = MSB
- req_op  input  [0:1]  00 pass, 01 complement, 10 logical right shift, 11 logical left shift
- req_amt  input  [0:1]  shift amount 0..3; ignored for pass and complement
- req_chain  input  1  1 = operate on the unit's current output instead of req_data
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  [0:3]  captured result
- sd_load  output  1  shift-unit register load
- sd_rg  output  1  shift-unit recirculate select
- sd_ch  output  [0:1]  shift-unit operation select
- sd_sh  output  [0:1]  shift-unit amount select
- sd_in  output  [0:3]  shift-unit parallel input
- sd_out  input  [0:3]  shift-unit result (combinational from its register)
- done_cnt  output  CNT_W  commands completed, wraps

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - req_ready=1, rsp_valid=0, rsp_data=0000
  - sd_load=0, sd_rg=0, sd_ch=00, sd_sh=00, sd_in=0000
  - done_cnt=0
  - Reset mid-command abandons the command; no response is produced.
- FSM states IDLE, LOAD, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch data/op/amt/chain into command registers and go to LOAD.
- LOAD, exactly one cycle:
  - sd_load=1, sd_rg=latched chain, sd_in=latched data.
  - sd_ch=op, sd_sh=amt (forced to 00 when op is 00 or 01).
  - Go to SETTLE.
- SETTLE:
  - sd_load=0; sd_ch/sd_sh held.
  - Count SETTLE_CYC cycles. On the last cycle, register sd_out into rsp_data, set rsp_valid=1, go to RESP.
  - Minimum accept-to-rsp_valid latency is 2+SETTLE_CYC cycles (3 at default).
- RESP:
  - rsp_valid and rsp_data held stable until rsp_ready.
  - sd_ch/sd_sh return to 00 on entry, so the unit shows its register contents.
  - On rsp_valid&rsp_ready: rsp_valid=0, done_cnt+1 (wraps 2^CNT_W-1 -> 0), go to IDLE.
  - No zero-cycle turnaround: req_ready rises the cycle after the response handshake.
- Chaining:
  - sd_rg=1 reloads the unit with its current sd_out. Because sd_ch=00 in IDLE/RESP, that value equals the last stored result.
  - Chain as the first command after reset operates on 0000.
- req_ready=0 outside IDLE. req_* is ignored while busy; a held req_valid is taken on return to IDLE.
- Shift semantics, bit 0 = MSB, zero fill:
  - Right shift moves bits toward index 3.
  - Left shift moves bits toward index 0.
  - Amount 0 = pass.

Optional Feature:
- Macro SHIFT_CMD_DRIVER_CHECK_EN.
- Defined:
  - An internal reference model computes the expected result from the latched operand (or the last rsp_data when chaining) and op/amt.
  - Extra output chk_err (1 bit) sets sticky on any capture mismatch; cleared only by reset.
  - Extra output chk_cnt (CNT_W) counts mismatches, saturating.
- Undefined: no model, no extra ports, identical timing.

Decomposition:
- Package shift_cmd_pkg holds:
  - op encodings OP_PASS/OP_CMPL/OP_SHR/OP_SHL
  - FSM state enum
  - DATA_W=4
- Natural sub-module: shift_cmd_ref_model, a combinational expected-result function of (data, op, amt).
  - Instantiated only under SHIFT_CMD_DRIVER_CHECK_EN.
  - Reused by the bench scoreboard.

Test Plan:
- Reset check: assert reset=0 mid-SETTLE -> rsp_valid=0, req_ready=1, sd_load=0, done_cnt=0, no stale response after release.
- Shift left: data 1011, op 11, amt 01, chain 0 -> sd_load pulses one cycle with sd_in=1011; rsp_data=0110 3 cycles after accept; done_cnt=1.
- Right shift and complement: data 1011 op 10 amt 10 -> 0010; data 1011 op 01 -> 0100, with sd_sh=00 during the complement.
- Chaining: after 0110, chain=1 op 10 amt 01 -> sd_rg=1 in LOAD, rsp_data=0011; chain as the first command after reset -> 0000.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0, a second req_valid is not taken until after the handshake.
- Wrap and check: 256 back-to-back commands -> done_cnt returns to 0. With the macro defined and sd_out forced to a wrong value -> chk_err=1 and chk_cnt increments.
